if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction memory through a req/ready handshake.
- Presents the fetched word and its PC+4 to IF/ID, together with the 2-bit IF/ID control code: 0 = load, 1 = hold, 2 = flush.
- Absorbs downstream stalls with a one-entry hold buffer and discards in-flight fetches on a branch or jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard unit requests IF/ID hold.
- redirect  in  1  branch/jump taken; flush IF/ID and refetch.
- redirect_pc  in  32  target address; bits [1:0] ignored, forced to 00.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; word-aligned; held stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory accepts and returns data this cycle.
- imem_rdata  in  32  instruction word; valid only when imem_req&imem_ready.
- instr_out  out  32  instruction toward IF/ID.
- pc_plus4_out  out  32  PC+4 of instr_out.
- ifid_ctl  out  2  IF/ID control: 0 load, 1 hold, 2 flush.

Behaviour:
- Registers:
  - pc_q, reset to RESET_PC.
  - state, reset to FETCH.
  - kill_addr, reset to 0.
  - hold_instr, reset to 0.
  - hold_pc4, reset to 0.
- States: FETCH, HOLD, KILL.
- Combinational outputs:
  - imem_req = 1 in FETCH and KILL; 0 in HOLD and while Reset=0.
  - imem_addr = pc_q in FETCH; kill_addr in KILL; pc_q in HOLD (don't-care, since req=0).
  - In FETCH: instr_out = imem_rdata, pc_plus4_out = pc_q+4.
  - In HOLD: instr_out = hold_instr, pc_plus4_out = hold_pc4.
  - In KILL: instr_out = 0, pc_plus4_out = 0.
  - While Reset=0: ifid_ctl=2, instr_out=0, pc_plus4_out=0.
- Transfer: completes at the rising edge where imem_req=1 and imem_ready=1. Zero-wait memory (ready high in the request cycle) is legal and sustains 1 instruction per cycle.
- Per-cycle priority: redirect > stall > normal.
- redirect=1, all states: ifid_ctl=2; pc_q <= {redirect_pc[31:2],2'b00}.
  - FETCH & ready: returned word dropped; stay FETCH.
  - FETCH & !ready: kill_addr <= pc_q; go to KILL. The old request stays on the bus until accepted.
  - HOLD: buffer discarded; go to FETCH.
  - KILL: pc_q takes the latest target; stay KILL.
- stall=1, redirect=0: ifid_ctl=1.
  - FETCH & ready: hold_instr <= imem_rdata; hold_pc4 <= pc_q+4; pc_q <= pc_q+4; go to HOLD.
  - FETCH & !ready: no change.
  - HOLD: no change.
  - KILL: on ready go to FETCH; otherwise stay.
- Normal (no redirect, no stall):
  - FETCH & ready: ifid_ctl=0; pc_q <= pc_q+4.
  - FETCH & !ready: ifid_ctl=1.
  - HOLD: ifid_ctl=0 (buffer delivered); go to FETCH. The next request issues in the following cycle.
  - KILL: ifid_ctl=1; on ready go to FETCH. The dropped word never reaches instr_out with ctl=0.
- Invariant: ifid_ctl=0 only when instr_out/pc_plus4_out carry a valid, unkilled instruction.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000, no flag.
- Reset asserted mid-transfer:
  - All registers return to reset values immediately.
  - The abandoned request is dropped.
  - The memory side must treat req falling as cancellation.
- Stall and redirect asserted together: redirect wins; ctl=2.

Test Plan:
- Reset release, RESET_PC=0, ready tied 1 -> imem_addr 0,4,8,C on consecutive cycles; ctl=0 each cycle; pc_plus4_out 4,8,C,10.
- Memory with 3-cycle latency at addr 0x40, rdata=0x8C220000 -> ctl=1 for 3 cycles; then ctl=0, instr_out=0x8C220000, pc_plus4_out=0x44; addr stable throughout.
- stall high 2 cycles while ready=1 at addr 0x10 (word 0x1234ABCD) -> captured in HOLD; req=0 and ctl=1 for the stall cycles; after stall drops, one cycle ctl=0, instr_out=0x1234ABCD, pc4=0x14; then fetch of 0x14.
- redirect to 0x203 while a fetch to 0x20 waits 2 more cycles -> ctl=2 that cycle; addr stays 0x20 until ready; that word is never loaded (ctl≠0); next fetch addr=0x200.
- redirect and stall together in HOLD -> ctl=2, buffer discarded, next addr=redirect target; separately, start pc=0xFFFFFFFC, ready=1 -> pc4=0x0, next addr=0x0.
- Reset pulsed low mid-wait -> req=0, ctl=2 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem via req/ready, presents the fetched word
// and its PC+4 to IF/ID with a load/hold/flush control code.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic [1:0]  ifid_ctl
);

  localparam logic [1:0] CtlLoad  = 2'd0;
  localparam logic [1:0] CtlHold  = 2'd1;
  localparam logic [1:0] CtlFlush = 2'd2;

  typedef enum logic [1:0] {StFetch, StHold, StKill} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  logic [31:0] pc_inc;
  logic [31:0] target;

  assign pc_inc = pc_q + 32'd4;
  assign target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    if (redirect) begin
      pc_d = target;
      unique case (state_q)
        StFetch: begin
          // The outstanding request must still complete; remember it so it can be drained.
          if (!imem_ready) begin
            kill_addr_d = pc_q;
            state_d     = StKill;
          end
        end
        StHold:  state_d = StFetch;
        StKill:  state_d = StKill;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ready) begin
            pc_d = pc_inc;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc4_d   = pc_inc;
              state_d      = StHold;
            end
          end
        end
        StHold:  if (!stall) state_d = StFetch;
        StKill:  if (imem_ready) state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      kill_addr_q  <= 32'd0;
      hold_instr_q <= 32'd0;
      hold_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign imem_req  = Reset && (state_q != StHold);
  assign imem_addr = (state_q == StKill) ? kill_addr_q : pc_q;

  always_comb begin
    instr_out    = 32'd0;
    pc_plus4_out = 32'd0;
    ifid_ctl     = CtlFlush;
    if (Reset) begin
      unique case (state_q)
        StFetch: begin
          instr_out    = imem_rdata;
          pc_plus4_out = pc_inc;
        end
        StHold: begin
          instr_out    = hold_instr_q;
          pc_plus4_out = hold_pc4_q;
        end
        default: ;
      endcase
      if (redirect) begin
        ifid_ctl = CtlFlush;
      end else if (stall) begin
        ifid_ctl = CtlHold;
      end else begin
        unique case (state_q)
          StFetch: ifid_ctl = imem_ready ? CtlLoad : CtlHold;
          StHold:  ifid_ctl = CtlLoad;
          default: ifid_ctl = CtlHold;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations plus a randomized run,
// every cycle checked against a behavioural model of the fetch stage.
module tb_if_fetch_stage;

  logic        clk;
  logic        Reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4_out;
  logic [1:0]  ifid_ctl;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_plus4_out (pc_plus4_out),
    .ifid_ctl     (ifid_ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the stage: the PC to fetch next, whether a word is parked for IF/ID,
  // and whether a request must still be drained and discarded.
  logic [31:0] m_pc;
  logic        m_parked;
  logic [31:0] m_park_word, m_park_pc4;
  logic        m_draining;
  logic [31:0] m_drain_addr;

  // Values sampled from the DUT by the last step.
  logic        s_req;
  logic [31:0] s_addr, s_instr, s_pc4;
  logic [1:0]  s_ctl;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc         = 32'h0000_0000;
    m_parked     = 1'b0;
    m_park_word  = 32'd0;
    m_park_pc4   = 32'd0;
    m_draining   = 1'b0;
    m_drain_addr = 32'd0;
  endtask

  task automatic sample();
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_instr = instr_out;
    s_pc4   = pc_plus4_out;
    s_ctl   = ifid_ctl;
  endtask

  // Called at posedge+1: drive one cycle, compare at negedge against the model, advance model.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] rdat);
    logic        e_req;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic [1:0]  e_ctl;
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    imem_ready  = rdy;
    imem_rdata  = rdat;
    @(negedge clk);
    sample();
    if (m_parked) begin
      e_req = 1'b0; e_addr = 32'd0; e_instr = m_park_word; e_pc4 = m_park_pc4;
    end else if (m_draining) begin
      e_req = 1'b1; e_addr = m_drain_addr; e_instr = 32'd0; e_pc4 = 32'd0;
    end else begin
      e_req = 1'b1; e_addr = m_pc; e_instr = rdat; e_pc4 = m_pc + 32'd4;
    end
    if (rd)                  e_ctl = 2'd2;
    else if (st)             e_ctl = 2'd1;
    else if (m_parked)       e_ctl = 2'd0;
    else if (m_draining)     e_ctl = 2'd1;
    else                     e_ctl = rdy ? 2'd0 : 2'd1;
    chk("req", {31'd0, s_req}, {31'd0, e_req});
    if (e_req) chk("addr", s_addr, e_addr);
    chk("instr", s_instr, e_instr);
    chk("pc4", s_pc4, e_pc4);
    chk("ctl", {30'd0, s_ctl}, {30'd0, e_ctl});
    // Advance the model for the upcoming edge.
    if (rd) begin
      if (m_parked) m_parked = 1'b0;
      else if (!m_draining && !rdy) begin
        m_draining   = 1'b1;
        m_drain_addr = m_pc;
      end
      m_pc = {tgt[31:2], 2'b00};
    end else if (m_parked) begin
      if (!st) m_parked = 1'b0;
    end else if (m_draining) begin
      if (rdy) m_draining = 1'b0;
    end else if (rdy) begin
      if (st) begin
        m_parked    = 1'b1;
        m_park_word = rdat;
        m_park_pc4  = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: reset asserted mid-cycle, outputs must react at once.
  task automatic pulse_reset();
    stall      = 1'b0;
    redirect   = 1'b0;
    imem_ready = 1'b0;
    Reset      = 1'b0;
    #1;
    sample();
    chk("rst_req", {31'd0, s_req}, 32'd0);
    chk("rst_ctl", {30'd0, s_ctl}, 32'd2);
    chk("rst_instr", s_instr, 32'd0);
    chk("rst_pc4", s_pc4, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    logic st, rd, rdy;
    logic [31:0] tgt;
    Reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'd0;
    model_reset();
    @(posedge clk);
    #1;
    sample();
    chk("por_req", {31'd0, s_req}, 32'd0);
    chk("por_ctl", {30'd0, s_ctl}, 32'd2);
    chk("por_instr", s_instr, 32'd0);
    Reset = 1'b1;

    // Zero-wait streaming from RESET_PC.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, memword(imem_addr));
      chk("seq_addr", s_addr, 32'(i * 4));
      chk("seq_pc4", s_pc4, 32'(i * 4 + 4));
      chk("seq_ctl", {30'd0, s_ctl}, 32'd0);
    end

    // Stall captures the word at 0x10 into the hold buffer.
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h1234_ABCD);
    chk("st_addr", s_addr, 32'h10);
    chk("st_ctl0", {30'd0, s_ctl}, 32'd1);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
    chk("st_req", {31'd0, s_req}, 32'd0);
    chk("st_ctl1", {30'd0, s_ctl}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF);
    chk("st_ld_ctl", {30'd0, s_ctl}, 32'd0);
    chk("st_ld_instr", s_instr, 32'h1234_ABCD);
    chk("st_ld_pc4", s_pc4, 32'h14);
    step(1'b0, 1'b0, 32'd0, 1'b1, memword(imem_addr));
    chk("st_next_addr", s_addr, 32'h14);

    // Three wait cycles at 0x40.
    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'hFFFF_0000);
      chk("lat_ctl", {30'd0, s_ctl}, 32'd1);
      chk("lat_addr", s_addr, 32'h40);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h8C22_0000);
    chk("lat_ld_ctl", {30'd0, s_ctl}, 32'd0);
    chk("lat_ld_instr", s_instr, 32'h8C22_0000);
    chk("lat_ld_pc4", s_pc4, 32'h44);

    // Redirect to 0x203 while the fetch of 0x20 is still waiting.
    step(1'b0, 1'b1, 32'h20, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h203, 1'b0, 32'h0);
    chk("rd_ctl", {30'd0, s_ctl}, 32'd2);
    chk("rd_addr", s_addr, 32'h20);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
    chk("kill_addr0", s_addr, 32'h20);
    chk("kill_ctl0", {30'd0, s_ctl}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, memword(32'h20));
    chk("kill_addr1", s_addr, 32'h20);
    chk("kill_ctl1", {30'd0, s_ctl}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, memword(32'h200));
    chk("rd_new_addr", s_addr, 32'h200);
    chk("rd_new_ctl", {30'd0, s_ctl}, 32'd0);

    // Redirect with stall while holding, to the top of the address space.
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h1111_2222);
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("rs_ctl", {30'd0, s_ctl}, 32'd2);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3333_4444);
    chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4", s_pc4, 32'h0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h5555_6666);
    chk("wrap_next", s_addr, 32'h0);

    // Reset while a fetch is waiting.
    step(1'b0, 1'b1, 32'h80, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'h0);
    pulse_reset();
    step(1'b0, 1'b0, 32'd0, 1'b1, memword(imem_addr));
    chk("rst_restart", s_addr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        pulse_reset();
      end else begin
        st  = ($urandom_range(3) == 0);
        rd  = ($urandom_range(9) == 0);
        rdy = ($urandom_range(9) < 6);
        tgt = $urandom;
        step(st, rd, tgt, rdy, rdy ? memword(imem_addr) : $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
